// File: rtl/hps_rst_pkg.sv
// hps_rst_pkg: shared types, STM event bit positions and sizing helper for the HPS reset-request sequencer
package hps_rst_pkg;
    typedef enum logic [2:0] {IDLE, ASSERT, WAIT_ACK, WAIT_REL, HOLDOFF} state_t;
    typedef enum logic [1:0] {CAUSE_COLD, CAUSE_WARM, CAUSE_DEBUG} cause_t;
    localparam int STM_COLD    = 0;
    localparam int STM_WARM    = 1;
    localparam int STM_DEBUG   = 2;
    localparam int STM_TIMEOUT = 3;
    localparam int STM_RELEASE = 4;
    localparam int STM_EVENTS  = 5;
    localparam int STM_CNT_W   = 12;
    localparam int STM_W       = 28;
    function automatic int max3(input int a, input int b, input int c);
        return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
    endfunction
endpackage

// File: rtl/req_debounce.sv
// req_debounce: synchronises a raw request, debounces it and emits a one-cycle strobe on its settled rising edge
module req_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic strobe
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [1:0]    sync;
    logic          stable;
    logic          stable_d;
    logic [DW-1:0] cnt;
    // sync chain, stability counter, and registered rising-edge strobe of the settled level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync     <= '0;
            stable   <= 1'b0;
            stable_d <= 1'b0;
            cnt      <= '0;
            strobe   <= 1'b0;
        end else begin
            sync     <= {sync[0], din};
            stable_d <= stable;
            strobe   <= stable & ~stable_d;
            if (sync[1] == stable) begin
                cnt <= '0;
            end else if (cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
                stable <= sync[1];
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/hps_reset_req_sequencer.sv
// hps_reset_req_sequencer: arbitrates debounced fabric reset requests into timed HPS f2h reset-request pulses
module hps_reset_req_sequencer
    import hps_rst_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int PULSE_CYCLES    = 256,
    parameter int ACK_TIMEOUT     = 5_000_000,
    parameter int HOLDOFF_CYCLES  = 50_000_000
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic        req_cold,
    input  logic        req_warm,
    input  logic        req_debug,
    input  logic        h2f_reset_n,
    output logic        f2h_cold_reset_req_n,
    output logic        f2h_warm_reset_req_n,
    output logic        f2h_debug_reset_req_n,
    output logic [27:0] stm_hwevents,
    output logic        busy,
    output logic        ack_timeout
);
    localparam int CW = $clog2(max3(PULSE_CYCLES, ACK_TIMEOUT, HOLDOFF_CYCLES) + 1);

    logic                  s_cold, s_warm, s_debug;
    logic [1:0]            h2f_sync;
    logic                  h2f;
    state_t                state, state_n;
    cause_t                cause, cause_n;
    logic [CW-1:0]         cnt, cnt_n;
    logic                  seen, seen_n;
    logic                  to_set;
    logic [STM_EVENTS-1:0] ev, ev_q;
    logic [STM_CNT_W-1:0]  req_count;

    req_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cold  (.clk(clk_clk), .rst(reset_reset), .din(req_cold),  .strobe(s_cold));
    req_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_warm  (.clk(clk_clk), .rst(reset_reset), .din(req_warm),  .strobe(s_warm));
    req_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debug (.clk(clk_clk), .rst(reset_reset), .din(req_debug), .strobe(s_debug));

    assign h2f          = h2f_sync[1];
    assign busy         = (state != IDLE);
    assign stm_hwevents = {{(STM_W - STM_EVENTS - STM_CNT_W){1'b0}}, req_count, ev_q};

    // state, shared down-counter, latched cause and registered outputs
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            h2f_sync              <= 2'b11;
            state                 <= IDLE;
            cause                 <= CAUSE_COLD;
            cnt                   <= '0;
            seen                  <= 1'b0;
            ev_q                  <= '0;
            req_count             <= '0;
            ack_timeout           <= 1'b0;
            f2h_cold_reset_req_n  <= 1'b1;
            f2h_warm_reset_req_n  <= 1'b1;
            f2h_debug_reset_req_n <= 1'b1;
        end else begin
            h2f_sync              <= {h2f_sync[0], h2f_reset_n};
            state                 <= state_n;
            cause                 <= cause_n;
            cnt                   <= cnt_n;
            seen                  <= seen_n;
            ev_q                  <= ev;
            req_count             <= (ev[STM_DEBUG:STM_COLD] != '0 && req_count != '1) ? req_count + 1'b1 : req_count;
            ack_timeout           <= ack_timeout | to_set;
            f2h_cold_reset_req_n  <= !(state_n == ASSERT && cause_n == CAUSE_COLD);
            f2h_warm_reset_req_n  <= !(state_n == ASSERT && cause_n == CAUSE_WARM);
            f2h_debug_reset_req_n <= !(state_n == ASSERT && cause_n == CAUSE_DEBUG);
        end
    end

    // next-state: accept strobes only in IDLE, pulse, await HPS ack/release, then hold off
    always_comb begin
        state_n = state;
        cause_n = cause;
        cnt_n   = (cnt == '0) ? '0 : cnt - 1'b1;
        seen_n  = seen;
        to_set  = 1'b0;
        ev      = '0;
        case (state)
            IDLE: begin
                if (s_cold || s_warm || s_debug) begin
                    state_n        = ASSERT;
                    cnt_n          = CW'(PULSE_CYCLES - 1);
                    seen_n         = 1'b0;
                    cause_n        = s_cold ? CAUSE_COLD : s_warm ? CAUSE_WARM : CAUSE_DEBUG;
                    ev[STM_COLD]   = s_cold;
                    ev[STM_WARM]   = !s_cold && s_warm;
                    ev[STM_DEBUG]  = !s_cold && !s_warm;
                end
            end
            ASSERT: begin
                seen_n = seen || !h2f;
                if (cnt == '0) begin
                    state_n = (cause == CAUSE_DEBUG) ? HOLDOFF : WAIT_ACK;
                    cnt_n   = (cause == CAUSE_DEBUG) ? CW'(HOLDOFF_CYCLES - 1) : CW'(ACK_TIMEOUT - 1);
                end
            end
            WAIT_ACK: begin
                if (seen || !h2f) begin
                    state_n = WAIT_REL;
                end else if (cnt == '0) begin
                    state_n          = HOLDOFF;
                    cnt_n            = CW'(HOLDOFF_CYCLES - 1);
                    to_set           = 1'b1;
                    ev[STM_TIMEOUT]  = 1'b1;
                end
            end
            WAIT_REL: begin
                if (h2f) begin
                    state_n          = HOLDOFF;
                    cnt_n            = CW'(HOLDOFF_CYCLES - 1);
                    ev[STM_RELEASE]  = 1'b1;
                end
            end
            HOLDOFF: state_n = (cnt == '0) ? IDLE : HOLDOFF;
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_hps_reset_req_sequencer.sv
// tb_hps_reset_req_sequencer: scoreboard bench for pulses, STM events, holdoff/timeout timing and reset abort
module tb_hps_reset_req_sequencer;
    logic        clk = 1'b0;
    logic        reset_reset, req_cold, req_warm, req_debug, h2f_reset_n;
    logic        f2h_cold_reset_req_n, f2h_warm_reset_req_n, f2h_debug_reset_req_n;
    logic [27:0] stm_hwevents;
    logic        busy, ack_timeout;

    typedef struct {int line; int width;} pulse_t;
    pulse_t exp_q[$];
    int     exp_ev[$];
    int     vectors = 0;
    int     miscompares = 0;
    int     n;

    hps_reset_req_sequencer #(
        .DEBOUNCE_CYCLES(8), .PULSE_CYCLES(4), .ACK_TIMEOUT(20), .HOLDOFF_CYCLES(10)
    ) dut (
        .clk_clk(clk), .reset_reset(reset_reset),
        .req_cold(req_cold), .req_warm(req_warm), .req_debug(req_debug),
        .h2f_reset_n(h2f_reset_n),
        .f2h_cold_reset_req_n(f2h_cold_reset_req_n),
        .f2h_warm_reset_req_n(f2h_warm_reset_req_n),
        .f2h_debug_reset_req_n(f2h_debug_reset_req_n),
        .stm_hwevents(stm_hwevents), .busy(busy), .ack_timeout(ack_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic bit cond(input int sel);
        case (sel)
            0: return !f2h_cold_reset_req_n;
            1: return !f2h_warm_reset_req_n;
            2: return !f2h_debug_reset_req_n;
            3: return f2h_cold_reset_req_n && f2h_warm_reset_req_n && f2h_debug_reset_req_n;
            4: return stm_hwevents[4];
            5: return !busy;
            default: return stm_hwevents[3];
        endcase
    endfunction

    task automatic wait_for(input int sel, input int max_cyc, input string tag, output int cyc);
        cyc = 0;
        while (!cond(sel) && cyc < max_cyc) begin
            @(negedge clk);
            cyc++;
        end
        check(tag, int'(cond(sel)), 1);
    endtask

    task automatic hps_ack();
        repeat (3) @(negedge clk);
        h2f_reset_n = 1'b0;
        repeat (30) @(negedge clk);
        h2f_reset_n = 1'b1;
    endtask

    // monitor: measure each req_n pulse and each STM event pulse, compare against the scoreboard
    initial begin
        int w = 0;
        int line = 0;
        pulse_t e;
        forever begin
            @(negedge clk);
            if (!cond(3)) begin
                w++;
                line = {29'd0, ~f2h_debug_reset_req_n, ~f2h_warm_reset_req_n, ~f2h_cold_reset_req_n};
            end else if (w > 0) begin
                if (exp_q.size() == 0) check("unexpected_pulse", line, 0);
                else begin
                    e = exp_q.pop_front();
                    check("pulse_line", line, e.line);
                    check("pulse_width", w, e.width);
                end
                w = 0;
            end
            if (stm_hwevents[4:0] != 5'd0) begin
                if (exp_ev.size() == 0) check("unexpected_event", int'(stm_hwevents[4:0]), 0);
                else check("stm_event", int'(stm_hwevents[4:0]), exp_ev.pop_front());
            end
        end
    end

    initial begin
        reset_reset = 1'b1;
        req_cold    = 1'b0;
        req_warm    = 1'b0;
        req_debug   = 1'b0;
        h2f_reset_n = 1'b1;
        #1;
        check("rst_cold_n", f2h_cold_reset_req_n, 1);
        check("rst_warm_n", f2h_warm_reset_req_n, 1);
        check("rst_debug_n", f2h_debug_reset_req_n, 1);
        check("rst_busy", busy, 0);
        check("rst_ack_timeout", ack_timeout, 0);
        check("rst_stm", int'(stm_hwevents), 0);
        repeat (3) @(negedge clk);
        reset_reset = 1'b0;

        exp_q.push_back('{1, 4});
        exp_ev.push_back(1);
        exp_ev.push_back(16);
        req_cold = 1'b1;
        wait_for(0, 30, "t1_low", n);
        check("t1_latency", n, 12);
        req_cold = 1'b0;
        wait_for(3, 20, "t1_rise", n);
        hps_ack();
        wait_for(4, 20, "t1_release", n);
        wait_for(5, 30, "t1_idle", n);
        check("t1_holdoff", n, 10);
        check("t1_count", int'(stm_hwevents[16:5]), 1);

        for (int i = 0; i < 40; i++) begin
            if (i % 3 == 0) req_warm = ~req_warm;
            @(negedge clk);
        end
        req_warm = 1'b0;
        repeat (30) @(negedge clk);
        check("t2_busy", busy, 0);
        check("t2_count", int'(stm_hwevents[16:5]), 1);

        exp_q.push_back('{1, 4});
        exp_ev.push_back(1);
        exp_ev.push_back(16);
        req_cold  = 1'b1;
        req_warm  = 1'b1;
        req_debug = 1'b1;
        wait_for(0, 30, "t3_low", n);
        req_cold  = 1'b0;
        req_warm  = 1'b0;
        req_debug = 1'b0;
        wait_for(3, 20, "t3_rise", n);
        hps_ack();
        wait_for(4, 20, "t3_release", n);
        wait_for(5, 30, "t3_idle", n);
        check("t3_count", int'(stm_hwevents[16:5]), 2);

        exp_q.push_back('{4, 4});
        exp_ev.push_back(4);
        req_debug = 1'b1;
        wait_for(2, 30, "t4_low", n);
        req_debug = 1'b0;
        wait_for(3, 20, "t4_rise", n);
        wait_for(5, 30, "t4_idle", n);
        check("t4_holdoff", n, 10);
        check("t4_count", int'(stm_hwevents[16:5]), 3);
        check("t4_ack_timeout", ack_timeout, 0);

        exp_q.push_back('{2, 4});
        exp_ev.push_back(2);
        exp_ev.push_back(8);
        req_warm = 1'b1;
        wait_for(1, 30, "t5_low", n);
        req_warm = 1'b0;
        wait_for(3, 20, "t5_rise", n);
        wait_for(6, 40, "t5_timeout", n);
        check("t5_timeout_cycles", n, 20);
        check("t5_ack_timeout", ack_timeout, 1);
        wait_for(5, 30, "t5_idle", n);
        check("t5_ack_sticky", ack_timeout, 1);
        check("t5_count", int'(stm_hwevents[16:5]), 4);

        exp_q.push_back('{1, 2});
        exp_ev.push_back(1);
        req_cold = 1'b1;
        wait_for(0, 30, "t6_low", n);
        @(negedge clk);
        reset_reset = 1'b1;
        #1;
        check("t6_abort_cold_n", f2h_cold_reset_req_n, 1);
        check("t6_abort_busy", busy, 0);
        check("t6_abort_count", int'(stm_hwevents[16:5]), 0);
        check("t6_abort_ack_timeout", ack_timeout, 0);
        req_cold = 1'b0;
        repeat (3) @(negedge clk);
        reset_reset = 1'b0;
        exp_q.push_back('{1, 4});
        exp_ev.push_back(1);
        exp_ev.push_back(16);
        req_cold = 1'b1;
        wait_for(0, 30, "t6_low2", n);
        check("t6_latency", n, 12);
        req_cold = 1'b0;
        wait_for(3, 20, "t6_rise", n);
        hps_ack();
        wait_for(4, 20, "t6_release", n);
        wait_for(5, 30, "t6_idle", n);
        check("t6_count", int'(stm_hwevents[16:5]), 1);

        repeat (5) @(negedge clk);
        check("pending_pulses", exp_q.size(), 0);
        check("pending_events", exp_ev.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
